// File: rtl/buffer_fifo_pkg.sv
// buffer_fifo_pkg -- shared defaults and width typedefs for the buffer FIFO.
//   DW_DEF / AW_DEF : default data and pointer widths
//   DEPTH           : number of storage entries at the default pointer width
//   data_t / ptr_t / cnt_t : data word, pointer and occupancy types
package buffer_fifo_pkg;
  localparam int DW_DEF = 24;
  localparam int AW_DEF = 6;
  localparam int DEPTH  = 1 << AW_DEF;

  typedef logic [DW_DEF-1:0] data_t;
  typedef logic [AW_DEF-1:0] ptr_t;
  typedef logic [AW_DEF:0]   cnt_t;
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p -- 2**AW x DW storage, one write port and one registered read port.
// No bypass: a word written at edge N is readable from edge N+1.
// Contents are never reset.
//   memclk : clock
//   wren   : write enable, writes wrdata to mem[wrptr]
//   rden   : read enable, loads mem[rdptr] into rddata
//   rddata : registered read word, holds when rden=0
module fifo_mem_2p #(
  parameter int DW = 24,
  parameter int AW = 6
) (
  input  logic          memclk,
  input  logic          wren,
  input  logic          rden,
  input  logic [AW-1:0] wrptr,
  input  logic [AW-1:0] rdptr,
  input  logic [DW-1:0] wrdata,
  output logic [DW-1:0] rddata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge memclk) begin
    if (wren) mem[wrptr] <= wrdata;
    if (rden) rddata <= mem[rdptr];
  end
endmodule

// File: rtl/buffer_fifo_ctrl.sv
// buffer_fifo_ctrl -- synchronous FIFO controller around fifo_mem_2p.
// Optional macro BUFFER_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
//   memclk  : clock (rising edge)
//   rst     : synchronous active-high reset
//   push    : write request, accepted when not full
//   wrdata  : write word
//   pop     : read request, accepted when not empty
//   rddata  : registered read word, 0 after reset until the first pop
//   rdvalid : one-cycle pulse after an accepted pop
//   full    : occupancy == DEPTH (registered)
//   empty   : occupancy == 0 (registered)
//   count   : occupancy 0..DEPTH
//   overflow / underflow : sticky error flags (macro builds only)
module buffer_fifo_ctrl
  import buffer_fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          memclk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wrdata,
  input  logic          pop,
  output logic [DW-1:0] rddata,
  output logic          rdvalid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
`ifdef BUFFER_FIFO_ERR_FLAGS_EN
  ,
  output logic          overflow,
  output logic          underflow
`endif
);
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wrptr, rdptr;
  logic          push_acc_p0, pop_acc_p0;
  logic [AW:0]   count_nxt;
  logic [DW-1:0] mem_rddata;
  logic          rd_zero;

  // Accept decisions use the registered flags, so push and pop are independent.
  assign push_acc_p0 = push & ~full  & ~rst;
  assign pop_acc_p0  = pop  & ~empty & ~rst;

  always_comb begin
    count_nxt = count;
    case ({push_acc_p0, pop_acc_p0})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Stage p0 -> p1: pointers, occupancy, flags and read pulse update.
  always_ff @(posedge memclk) begin
    if (rst) begin
      wrptr   <= '0;
      rdptr   <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rdvalid <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      if (push_acc_p0) wrptr <= wrptr + PTR_ONE;
      if (pop_acc_p0) begin
        rdptr   <= rdptr + PTR_ONE;
        rd_zero <= 1'b0;
      end
      count   <= count_nxt;
      full    <= (count_nxt == FULL_CNT);
      empty   <= (count_nxt == '0);
      rdvalid <= pop_acc_p0;
    end
  end

  fifo_mem_2p #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .memclk (memclk),
    .wren   (push_acc_p0),
    .rden   (pop_acc_p0),
    .wrptr  (wrptr),
    .rdptr  (rdptr),
    .wrdata (wrdata),
    .rddata (mem_rddata)
  );

  // The storage read register has no reset; rd_zero masks it to 0 after
  // reset until a pop reloads it, which keeps the word-hold behaviour.
  assign rddata = rd_zero ? '0 : mem_rddata;

`ifdef BUFFER_FIFO_ERR_FLAGS_EN
  always_ff @(posedge memclk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full)  overflow  <= 1'b1;
      if (pop  & empty) underflow <= 1'b1;
    end
  end
`endif
endmodule

// File: doc/buffer_fifo_ctrl.md
BUFFER_FIFO_CTRL -- requirements
Module: buffer_fifo_ctrl

Interface
REQ-001 Parameter DW, default 24: data word width in bits.
REQ-002 Parameter AW, default 6: pointer width in bits; DEPTH = 2**AW (64 entries).
REQ-003 memclk  in  1: single clock; all state updates on the rising edge.
REQ-004 rst  in  1: reset, synchronous, active-high.
REQ-005 push  in  1: write request.
REQ-006 wrdata  in  DW: write word, sampled on an accepted push.
REQ-007 pop  in  1: read request.
REQ-008 rddata  out  DW: read word, registered.
REQ-009 rdvalid  out  1: one-cycle pulse; rddata holds a newly popped word.
REQ-010 full  out  1: occupancy == DEPTH.
REQ-011 empty  out  1: occupancy == 0.
REQ-012 count  out  AW+1: current occupancy, range 0..DEPTH.

Function
REQ-013 A push SHALL be accepted iff push=1 and full=0; a rejected push SHALL change no state.
REQ-014 A pop SHALL be accepted iff pop=1 and empty=0; a rejected pop SHALL change no state.
REQ-015 Accept decisions SHALL use the registered full/empty of the current cycle, so push and pop on the same edge are evaluated independently.
REQ-016 An accepted push SHALL write wrdata to mem[wrptr] and advance wrptr by 1 modulo DEPTH (63 -> 0).
REQ-017 An accepted pop SHALL read mem[rdptr] into rddata at the same edge and advance rdptr by 1 modulo DEPTH.
REQ-018 rdvalid SHALL be 1 in the cycle after an accepted pop and 0 otherwise; read latency is exactly 1 cycle.
REQ-019 rddata SHALL hold its last value when no pop is accepted.
REQ-020 count SHALL increment on a push-only accept, decrement on a pop-only accept, and stay unchanged when both or neither are accepted.
REQ-021 full and empty SHALL be registered and derived from the next count value, so they are valid in the cycle after the causing edge.
REQ-022 Full with push=1 and pop=1: only the pop is accepted; count goes 64 -> 63 and full clears.
REQ-023 Empty with push=1 and pop=1: only the push is accepted; count goes 0 -> 1 and rdvalid stays 0.
REQ-024 Storage SHALL be a 2-port array (one write port, one registered read port) with no bypass; a word pushed at edge N is first poppable at edge N+1.

Reset
REQ-025 While rst=1 at a clock edge: wrptr=0, rdptr=0, count=0, empty=1, full=0, rdvalid=0, rddata=0; push and pop are ignored.
REQ-026 Storage contents SHALL NOT be reset.
REQ-027 Reset mid-operation SHALL discard all stored words; the first pop after reset returns the first word pushed after reset.

Configuration
REQ-028 With BUFFER_FIFO_ERR_FLAGS_EN defined: add outputs overflow (1) and underflow (1), both sticky and cleared only by rst.
REQ-029 overflow SHALL set on a push while full=1; underflow SHALL set on a pop while empty=1 (pop=1 with empty=1).
REQ-030 Without BUFFER_FIFO_ERR_FLAGS_EN: these ports and their logic SHALL NOT exist; all other behaviour is identical.

Structure
REQ-031 Shared package buffer_fifo_pkg SHALL hold DW/AW defaults, DEPTH, and the data/pointer/count width typedefs.
REQ-032 Storage SHALL be the sub-module fifo_mem_2p (ports: memclk, wren, rden, wrptr, rdptr, wrdata, rddata); buffer_fifo_ctrl holds the pointers, count, flags, rdvalid, and error flags.

Verification
REQ-033 After rst: push 0xA00001..0xA00003 on 3 cycles, then pop 3 cycles -> rddata 0xA00001, 0xA00002, 0xA00003 with rdvalid each cycle after pop; empty=1 at end.
REQ-034 Push 64 words -> full=1 and count=64; a 65th push -> ignored, count stays 64, overflow=1 if BUFFER_FIFO_ERR_FLAGS_EN.
REQ-035 Full with push+pop together -> count=63, full=0, popped word is the oldest, and the pushed word is dropped.
REQ-036 Empty with push+pop together -> count=1 and rdvalid=0; the next pop returns the pushed word.
REQ-037 Push/pop 100 words with count held at 5 -> both pointers wrap 63 -> 0 and the data order is preserved.
REQ-038 rst asserted with count=10 -> next cycle count=0, empty=1, rdvalid=0, rddata=0; a pop is ignored (underflow=1 if BUFFER_FIFO_ERR_FLAGS_EN).
